// File: rtl/fpu_issue_scheduler.sv
// ============================================================================
// Module   : fpu_issue_scheduler
// Purpose  : Single-issue FPU front end with a writeback reservation table
//            and a registered, tagged writeback bus.
// Revision : 1.0
// ============================================================================
`default_nettype none

module fpu_issue_scheduler #(
    parameter int TAG_W   = 5,
    parameter int LAT_ADD = 3,
    parameter int LAT_MUL = 2,
    parameter int LAT_CVT = 2,
    parameter int MAX_LAT = 8
) (
    input  logic             sys_clk,
    input  logic             rstn,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_op,
    input  logic [TAG_W-1:0] req_tag,
    input  logic [31:0]      req_a,
    input  logic [31:0]      req_b,
    output logic             add_valid,
    output logic             mul_valid,
    output logic             itof_valid,
    output logic             ftoi_valid,
    output logic [31:0]      opnd_a,
    output logic [31:0]      opnd_b,
    input  logic [31:0]      add_y,
    input  logic [31:0]      mul_y,
    input  logic [31:0]      itof_y,
    input  logic [31:0]      ftoi_y,
    input  logic             add_ov,
    input  logic             mul_ov,
    input  logic             itof_ov,
    input  logic             ftoi_ov,
    output logic             wb_valid,
    output logic [TAG_W-1:0] wb_tag,
    output logic [31:0]      wb_data,
    output logic             busy,
    output logic [1:0]       err
);

    localparam int LAT_W = $clog2(MAX_LAT + 1);

    localparam logic [1:0] c_unit_add  = 2'd0;
    localparam logic [1:0] c_unit_mul  = 2'd1;
    localparam logic [1:0] c_unit_itof = 2'd2;
    localparam logic [1:0] c_unit_ftoi = 2'd3;

    // Entry k of the table describes the result due k cycles from now.
    logic [MAX_LAT:0] occ_q, occ_d;
    logic [1:0]       unit_q [0:MAX_LAT];
    logic [1:0]       unit_d [0:MAX_LAT];
    logic [TAG_W-1:0] tag_q  [0:MAX_LAT];
    logic [TAG_W-1:0] tag_d  [0:MAX_LAT];

    logic             wb_valid_q, wb_valid_d;
    logic [TAG_W-1:0] wb_tag_q, wb_tag_d;
    logic [31:0]      wb_data_q, wb_data_d;
    logic [1:0]       err_q, err_d;

    logic             w_legal;
    logic [1:0]       w_unit;
    logic [LAT_W-1:0] w_lat;
    logic [LAT_W-1:0] w_slot;
    logic             w_accept;
    logic             w_issue;
    logic [3:0]       w_issue_vec;
    logic [3:0]       w_ov;
    logic [3:0]       w_due_mask;
    logic             w_capture;
    logic             w_proto_err;
    logic [31:0]      w_due_y;

    always_comb begin
        w_legal = 1'b1;
        w_unit  = c_unit_add;
        w_lat   = LAT_W'(LAT_ADD);
        case (req_op)
            3'd0, 3'd1: begin
                w_unit = c_unit_add;
                w_lat  = LAT_W'(LAT_ADD);
            end
            3'd2: begin
                w_unit = c_unit_mul;
                w_lat  = LAT_W'(LAT_MUL);
            end
            3'd3: begin
                w_unit = c_unit_itof;
                w_lat  = LAT_W'(LAT_CVT);
            end
            3'd4: begin
                w_unit = c_unit_ftoi;
                w_lat  = LAT_W'(LAT_CVT);
            end
            default: w_legal = 1'b0;
        endcase
    end

    // Illegal ops are swallowed immediately so they can never stall the port.
    assign req_ready   = w_legal ? ~occ_q[w_lat] : 1'b1;
    assign w_accept    = req_valid & req_ready;
    assign w_issue     = w_accept & w_legal;
    assign w_issue_vec = w_issue ? (4'b0001 << w_unit) : 4'b0000;
    assign w_slot      = w_lat - LAT_W'(1);

    assign add_valid  = w_issue_vec[0];
    assign mul_valid  = w_issue_vec[1];
    assign itof_valid = w_issue_vec[2];
    assign ftoi_valid = w_issue_vec[3];
    assign opnd_a     = req_a;
    assign opnd_b     = {req_b[31] ^ (req_op == 3'd1), req_b[30:0]};

    assign w_ov        = {ftoi_ov, itof_ov, mul_ov, add_ov};
    assign w_due_mask  = occ_q[0] ? (4'b0001 << unit_q[0]) : 4'b0000;
    assign w_capture   = |(w_ov & w_due_mask);
    assign w_proto_err = (occ_q[0] & ~w_capture) | (|(w_ov & ~w_due_mask));

    always_comb begin
        case (unit_q[0])
            c_unit_add:  w_due_y = add_y;
            c_unit_mul:  w_due_y = mul_y;
            c_unit_itof: w_due_y = itof_y;
            default:     w_due_y = ftoi_y;
        endcase
    end

    always_comb begin
        occ_d = {1'b0, occ_q[MAX_LAT:1]};
        for (int k = 0; k < MAX_LAT; k++) begin
            unit_d[k] = unit_q[k+1];
            tag_d[k]  = tag_q[k+1];
        end
        unit_d[MAX_LAT] = 2'd0;
        tag_d[MAX_LAT]  = '0;
        // Slot L after this edge's shift is entry L-1; accept already proved it free.
        if (w_issue) begin
            occ_d[w_slot]  = 1'b1;
            unit_d[w_slot] = w_unit;
            tag_d[w_slot]  = req_tag;
        end

        wb_valid_d = w_capture;
        wb_tag_d   = w_capture ? tag_q[0] : wb_tag_q;
        wb_data_d  = w_capture ? w_due_y  : wb_data_q;
        err_d      = err_q | {w_accept & ~w_legal, w_proto_err};
    end

    always_ff @(posedge sys_clk) begin
        if (!rstn) begin
            occ_q      <= '0;
            wb_valid_q <= 1'b0;
            wb_tag_q   <= '0;
            wb_data_q  <= '0;
            err_q      <= 2'b00;
            for (int k = 0; k <= MAX_LAT; k++) begin
                unit_q[k] <= 2'd0;
                tag_q[k]  <= '0;
            end
        end else begin
            occ_q      <= occ_d;
            wb_valid_q <= wb_valid_d;
            wb_tag_q   <= wb_tag_d;
            wb_data_q  <= wb_data_d;
            err_q      <= err_d;
            for (int k = 0; k <= MAX_LAT; k++) begin
                unit_q[k] <= unit_d[k];
                tag_q[k]  <= tag_d[k];
            end
        end
    end

    assign wb_valid = wb_valid_q;
    assign wb_tag   = wb_tag_q;
    assign wb_data  = wb_data_q;
    assign err      = err_q;
    assign busy     = |occ_q;

endmodule

`default_nettype wire

// File: tb/tb_fpu_issue_scheduler.sv
// ============================================================================
// Module   : tb_fpu_issue_scheduler
// Purpose  : Scoreboard bench for fpu_issue_scheduler with stub FPU units.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_fpu_issue_scheduler;

    localparam int TAG_W   = 5;
    localparam int LAT_ADD = 3;
    localparam int LAT_MUL = 2;
    localparam int LAT_CVT = 2;
    localparam int MAX_LAT = 8;

    logic             sys_clk = 1'b0;
    logic             rstn = 1'b0;
    logic             req_valid = 1'b0;
    logic             req_ready;
    logic [2:0]       req_op = 3'd0;
    logic [TAG_W-1:0] req_tag = '0;
    logic [31:0]      req_a = '0;
    logic [31:0]      req_b = '0;
    logic             add_valid, mul_valid, itof_valid, ftoi_valid;
    logic [31:0]      opnd_a, opnd_b;
    logic [31:0]      add_y, mul_y, itof_y, ftoi_y;
    logic             add_ov, mul_ov, itof_ov, ftoi_ov;
    logic             wb_valid;
    logic [TAG_W-1:0] wb_tag;
    logic [31:0]      wb_data;
    logic             busy;
    logic [1:0]       err;

    fpu_issue_scheduler #(
        .TAG_W(TAG_W), .LAT_ADD(LAT_ADD), .LAT_MUL(LAT_MUL),
        .LAT_CVT(LAT_CVT), .MAX_LAT(MAX_LAT)
    ) dut (
        .sys_clk(sys_clk), .rstn(rstn),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_tag(req_tag), .req_a(req_a), .req_b(req_b),
        .add_valid(add_valid), .mul_valid(mul_valid),
        .itof_valid(itof_valid), .ftoi_valid(ftoi_valid),
        .opnd_a(opnd_a), .opnd_b(opnd_b),
        .add_y(add_y), .mul_y(mul_y), .itof_y(itof_y), .ftoi_y(ftoi_y),
        .add_ov(add_ov), .mul_ov(mul_ov), .itof_ov(itof_ov), .ftoi_ov(ftoi_ov),
        .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_data(wb_data),
        .busy(busy), .err(err)
    );

    always #5 sys_clk = ~sys_clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Real int->float conversion (truncating) for the itof stub.
    function automatic logic [31:0] f_itof(input logic [31:0] x);
        logic        s;
        logic [31:0] m, mant;
        int          p;
        if (x == 32'd0) return 32'd0;
        s = x[31];
        m = s ? (~x + 32'd1) : x;
        p = 0;
        for (int i = 0; i < 32; i++) if (m[i]) p = i;
        mant = (p <= 23) ? (m << (23 - p)) : (m >> (p - 23));
        return {s, 8'(127 + p), mant[22:0]};
    endfunction

    function automatic logic [31:0] unit_fn(input int u, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        case (u)
            0:       r = a ^ b ^ 32'h8000_0000;
            1:       r = a * b;
            2:       r = f_itof(a);
            default: r = a ^ 32'h5A5A_5A5A;
        endcase
        return r;
    endfunction

    // Stub fixed-latency units sharing rstn.
    logic [3:0]         inj_ov = 4'b0;
    logic [3:0]         uv;
    logic [MAX_LAT-1:0] pv [4];
    logic [31:0]        pd [4][MAX_LAT];
    assign uv = {ftoi_valid, itof_valid, mul_valid, add_valid};

    always @(posedge sys_clk) begin
        for (int u = 0; u < 4; u++) begin
            if (!rstn) pv[u] <= '0;
            else       pv[u] <= {pv[u][MAX_LAT-2:0], uv[u]};
            for (int k = MAX_LAT - 1; k > 0; k--) pd[u][k] <= pd[u][k-1];
            pd[u][0] <= unit_fn(u, opnd_a, opnd_b);
        end
    end

    assign add_ov  = pv[0][LAT_ADD-1] | inj_ov[0];
    assign mul_ov  = pv[1][LAT_MUL-1] | inj_ov[1];
    assign itof_ov = pv[2][LAT_CVT-1] | inj_ov[2];
    assign ftoi_ov = pv[3][LAT_CVT-1] | inj_ov[3];
    assign add_y   = pd[0][LAT_ADD-1];
    assign mul_y   = pd[1][LAT_MUL-1];
    assign itof_y  = pd[2][LAT_CVT-1];
    assign ftoi_y  = pd[3][LAT_CVT-1];

    // Reference: every accepted op is an expected writeback at an absolute cycle.
    typedef struct {
        int               acc;
        int               wbc;
        logic [TAG_W-1:0] tag;
        logic [31:0]      data;
    } exp_t;
    exp_t q[$];

    logic [1:0] err_set = 2'b00;
    logic [1:0] err_exp = 2'b00;
    always @(posedge sys_clk) begin
        if (!rstn) err_exp <= 2'b00;
        else       err_exp <= err_exp | err_set;
    end

    logic [31:0] ob_seen;

    task automatic drive(input bit v, input logic [2:0] op, input logic [TAG_W-1:0] tag,
                         input logic [31:0] a, input logic [31:0] b, input logic [3:0] inj,
                         output bit acc, output bit rdy);
        int          u, l, pos;
        bit          legal, mready;
        logic [31:0] be;
        logic [3:0]  uv_exp;
        exp_t        e;
        @(posedge sys_clk);
        #1;
        req_valid = v; req_op = op; req_tag = tag; req_a = a; req_b = b;
        inj_ov = inj; err_set = 2'b00;
        @(negedge sys_clk);
        legal = (op <= 3'd4);
        u = (op <= 3'd1) ? 0 : (op == 3'd2) ? 1 : (op == 3'd3) ? 2 : 3;
        l = (u == 0) ? LAT_ADD : (u == 1) ? LAT_MUL : LAT_CVT;
        be = (op == 3'd1) ? {~b[31], b[30:0]} : b;
        mready = 1'b1;
        if (legal) foreach (q[i]) if (q[i].wbc == cyc + l + 1) mready = 1'b0;
        chk("req_ready", {31'b0, req_ready}, {31'b0, mready});
        acc = v && mready;
        rdy = req_ready;
        uv_exp = (acc && legal) ? (4'b0001 << u) : 4'b0000;
        chk("unit_valid", {28'b0, uv}, {28'b0, uv_exp});
        chk("opnd_a", opnd_a, a);
        chk("opnd_b", opnd_b, be);
        ob_seen = opnd_b;
        if (acc && legal) begin
            e.acc = cyc; e.wbc = cyc + l + 1; e.tag = tag; e.data = unit_fn(u, a, be);
            pos = q.size();
            for (int i = q.size() - 1; i >= 0; i--) if (q[i].wbc > e.wbc) pos = i;
            q.insert(pos, e);
        end
        if (acc && !legal) err_set[1] = 1'b1;
        if (|inj) err_set[0] = 1'b1;
    endtask

    task automatic idle();
        bit a_, r_;
        drive(1'b0, 3'd0, '0, 32'h0, 32'h0, 4'b0, a_, r_);
    endtask

    task automatic do_reset();
        @(posedge sys_clk);
        #1;
        rstn = 1'b0; req_valid = 1'b0; inj_ov = 4'b0; err_set = 2'b00;
        @(negedge sys_clk);
        q.delete();
        @(posedge sys_clk);
        #1;
        rstn = 1'b1;
        @(negedge sys_clk);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_err", {30'b0, err}, 32'd0);
        chk("rst_wb_valid", {31'b0, wb_valid}, 32'd0);
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() > 0 && n < 40) begin
            idle();
            n++;
        end
        if (q.size() > 0) begin
            total++; bad++;
            $display("FAIL drain: %0d writebacks outstanding, expected 0", q.size());
            q.delete();
        end
    endtask

    // Monitor: writebacks, busy and sticky error flags.
    always @(negedge sys_clk) begin
        if (rstn) begin
            int nb;
            nb = 0;
            foreach (q[i]) if (q[i].acc < cyc && q[i].wbc > cyc) nb++;
            chk("busy", {31'b0, busy}, {31'b0, nb != 0});
            chk("err", {30'b0, err}, {30'b0, err_exp});
            if (wb_valid) begin
                if (q.size() == 0 || q[0].wbc != cyc) begin
                    total++; bad++;
                    $display("FAIL wb_unexpected @cyc %0d: got tag %h data %h, expected no writeback",
                             cyc, wb_tag, wb_data);
                end else begin
                    chk("wb_tag", {27'b0, wb_tag}, {27'b0, q[0].tag});
                    chk("wb_data", wb_data, q[0].data);
                    void'(q.pop_front());
                end
            end else if (q.size() > 0 && q[0].wbc == cyc) begin
                total++; bad++;
                $display("FAIL wb_missing @cyc %0d: got wb_valid 0, expected tag %h", cyc, q[0].tag);
                void'(q.pop_front());
            end else begin
                chk("wb_idle", {31'b0, wb_valid}, 32'd0);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        bit acc, rdy;
        do_reset();

        // ITOF 5 -> 1 cycle issue, writeback three cycles later
        drive(1'b1, 3'd3, 5'd3, 32'h0000_0005, 32'h0, 4'b0, acc, rdy);
        chk("itof_rdy", {31'b0, rdy}, 32'd1);
        idle(); idle(); idle();
        chk("itof_wb_valid", {31'b0, wb_valid}, 32'd1);
        chk("itof_wb_tag", {27'b0, wb_tag}, 32'd3);
        chk("itof_wb_data", wb_data, 32'h40A0_0000);
        drain();

        // FADD then FMUL landing on the same due cycle
        drive(1'b1, 3'd0, 5'd10, 32'h1234_5678, 32'h0F0F_0F0F, 4'b0, acc, rdy);
        drive(1'b1, 3'd2, 5'd11, 32'h0000_0003, 32'h0000_0007, 4'b0, acc, rdy);
        chk("collide_stall", {31'b0, rdy}, 32'd0);
        drive(1'b1, 3'd2, 5'd11, 32'h0000_0003, 32'h0000_0007, 4'b0, acc, rdy);
        chk("collide_retry", {31'b0, rdy}, 32'd1);
        drain();

        // FSUB 1.0 - 1.0
        drive(1'b1, 3'd1, 5'd7, 32'h3F80_0000, 32'h3F80_0000, 4'b0, acc, rdy);
        chk("fsub_opnd_b", ob_seen, 32'hBF80_0000);
        idle(); idle(); idle(); idle();
        chk("fsub_wb_valid", {31'b0, wb_valid}, 32'd1);
        chk("fsub_wb_data", wb_data, 32'h0);
        drain();

        // Back-to-back ITOF
        for (int t = 1; t <= 4; t++) begin
            drive(1'b1, 3'd3, 5'(t), 32'(t * 100), 32'h0, 4'b0, acc, rdy);
            chk("b2b_rdy", {31'b0, rdy}, 32'd1);
        end
        drain();

        // Illegal op, then a spurious result with an empty table
        drive(1'b1, 3'd6, 5'd9, 32'h1, 32'h2, 4'b0, acc, rdy);
        chk("illegal_rdy", {31'b0, rdy}, 32'd1);
        idle();
        chk("illegal_err", {30'b0, err}, 32'd2);
        drive(1'b0, 3'd0, '0, 32'h0, 32'h0, 4'b0010, acc, rdy);
        idle();
        chk("spurious_err", {30'b0, err}, 32'd3);
        drain();

        // Reset with an add in flight
        drive(1'b1, 3'd0, 5'd5, 32'hAAAA_0000, 32'h0000_5555, 4'b0, acc, rdy);
        do_reset();
        for (int i = 0; i < 6; i++) idle();

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            bit          v;
            logic [2:0]  op;
            v  = ($urandom_range(0, 3) != 0);
            op = ($urandom_range(0, 11) == 0) ? 3'(5 + $urandom_range(0, 2)) : 3'($urandom_range(0, 4));
            drive(v, op, 5'($urandom), $urandom, $urandom, 4'b0, acc, rdy);
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/fpu_issue_scheduler.md
Name: fpu_issue_scheduler

Overview:
- Single-issue front end for the fixed-latency FPU pipelines: adder, multiplier, itof and ftoi.
- Accepts one operation per cycle on a valid/ready port and drives the matching unit's stage1_valid and operands.
- Tracks every in-flight result in a writeback reservation table, so at most one unit delivers a result in any cycle.
- Merges unit outputs onto a single registered, tagged writeback bus toward the register file.

Parameters:
- TAG_W, 5: destination register tag width.
- LAT_ADD, 3: cycles from fadd stage1_valid to out_valid.
- LAT_MUL, 2: cycles from fmul stage1_valid to out_valid.
- LAT_CVT, 2: cycles for itof and ftoi, stage1_valid to out_valid.
- MAX_LAT, 8: reservation table depth. Every LAT_* must satisfy 1 ≤ LAT ≤ MAX_LAT.

Ports:
- sys_clk, in, 1: clock.
- rstn, in, 1: reset.
- req_valid, in, 1: operation offered.
- req_ready, out, 1: operation accepted this cycle when high together with req_valid.
- req_op, in, 3: 0 FADD, 1 FSUB, 2 FMUL, 3 ITOF, 4 FTOI, 5-7 illegal.
- req_tag, in, TAG_W: destination tag.
- req_a, in, 32: operand A.
- req_b, in, 32: operand B.
- add_valid / mul_valid / itof_valid / ftoi_valid, out, 1 each: unit stage1_valid.
- opnd_a, out, 32: operand A broadcast to all units.
- opnd_b, out, 32: operand B broadcast to all units.
- add_y / mul_y / itof_y / ftoi_y, in, 32 each: unit results.
- add_ov / mul_ov / itof_ov / ftoi_ov, in, 1 each: unit out_valid.
- wb_valid, out, 1: writeback strobe (registered).
- wb_tag, out, TAG_W: writeback tag (registered).
- wb_data, out, 32: writeback data (registered).
- busy, out, 1: any reservation outstanding.
- err, out, 2: sticky errors. Bit 0 = protocol mismatch, bit 1 = illegal op.

Behaviour:
- Interface: reset rstn, synchronous, active-low; clock sys_clk.
- Reset clears:
  - the reservation table;
  - wb_valid, wb_tag, wb_data and err to 0;
  - all unit valids to 0.
- The units share rstn. Results already in flight at reset are discarded, and no err is raised for them.
- Reservation table: entries 0..MAX_LAT. Each entry holds occ, unit id (2 bits) and tag. occ[k] means a result is due k cycles from the current cycle.
- Accept rule, with L = latency of req_op:
  - req_ready = !occ[L], combinational.
  - Illegal ops always have req_ready = 1. They issue nothing and set err[1].
- Issue happens in the accept cycle, combinationally:
  - The selected unit valid is driven to req_valid & req_ready; the other unit valids are 0.
  - opnd_a = req_a, always.
  - opnd_b = req_b, except for FSUB, where opnd_b = req_b with bit 31 inverted.
- Each posedge:
  - Entry k takes entry k+1 for k = 0..MAX_LAT-1; entry MAX_LAT is cleared.
  - If an op was accepted, entry L-1 is loaded with {1, unit, tag}. Acceptance guarantees this slot was free.
- Result capture: when occ[0] is set, the due unit's out_valid must be high.
  - Next cycle: wb_valid = 1, wb_tag = entry0.tag, wb_data = that unit's y.
  - Otherwise wb_valid = 0; wb_tag and wb_data hold their previous values.
- Total latency from acceptance to wb_valid is L+1 cycles.
- Protocol check, which sets err[0]:
  - occ[0] is set and the due unit's ov is low; or
  - any ov is high for a unit other than entry0's unit, or with occ[0] clear.
  - Mismatching results are dropped.
- busy = OR of occ[0..MAX_LAT].
- Throughput:
  - Back-to-back ops to the same unit are allowed, one per cycle, since each lands in a distinct slot.
  - A shorter op stalls only when its slot is already reserved by a longer op issued earlier.
- An op and a due result in the same cycle are independent. The shift and insert happen in one posedge.
- err bits clear only on reset.

Test Plan:
- ITOF, req_a = 0x00000005, tag 3, accepted at t0 → itof_valid high at t0. wb at t3: wb_valid = 1, tag 3, data = 0x40A00000.
- FADD at t0 (L = 3), then FMUL at t1 (L = 2). The FMUL collides on the same due cycle:
  - req_ready low at t1, so FMUL accepted at t2;
  - wb at t4 = FADD result, wb at t5 = FMUL result.
- FSUB 0x3F800000 − 0x3F800000 → opnd_b = 0xBF800000 and add_valid high. wb_data = 0x00000000.
- Four consecutive ITOF ops with tags 1..4 → req_ready stays high. wb_valid high for 4 consecutive cycles, tags 1, 2, 3, 4 in order.
- req_op = 6 → accepted, no unit valid, err = 2'b10, wb_valid stays 0. An injected spurious mul_ov with the table empty → err = 2'b11.
- Issue FADD, then assert rstn low for 1 cycle at t1 → table cleared, busy = 0, no wb, err = 0.
